env_rate_sched: RTL and testbench
=================================

Name: env_rate_sched

Overview:
Time-multiplexed envelope rate scheduler. It shares one combinational 8-to-15-bit rate mapper among VOICES envelope channels. Each clock it visits one voice round-robin, presents that voice's rate register to the mapper, and runs the voice's 15-bit period down-counter from the mapped value. It emits one envelope step tick per voice each time that voice's period elapses. It sits between the CPU register file and the envelope generators.

Parameters:
VOICES, 8, number of voices; must be a power of two, 2..16
VW, 3, voice index width; must equal log2(VOICES)

Ports:
CLK  in  1  system clock
nRESET  in  1  asynchronous active-low reset
WR_EN  in  1  rate register write strobe, one cycle
WR_VOICE  in  VW  voice index for the write
WR_DATA  in  8  new 8-bit rate value
KEY_ON  in  1  key-on strobe, one cycle
KEY_OFF  in  1  key-off strobe, one cycle
KEY_VOICE  in  VW  voice index for the KEY_ON/KEY_OFF strobe
MAP_RATE  out  8  rate value presented to the shared mapper (registered)
MAP_TR  in  15  mapper result; combinational function of MAP_RATE
STEP_TICK  out  1  one-cycle pulse: a voice's period elapsed
STEP_VOICE  out  VW  voice index qualifying STEP_TICK
ACTIVE  out  VOICES  per-voice active flags

Behaviour:
- Single clock domain, CLK. nRESET is asynchronous and active-low.
- Reset state:
  - slot counter = 0
  - all rate registers = 0x00
  - all period counters = 0
  - ACTIVE = 0
  - MAP_RATE = 0x00
  - STEP_TICK = 0
  - STEP_VOICE = 0
  - pipeline valid = 0
- Slot counter: VW bits, increments every clock, wraps VOICES-1 -> 0. Each voice is visited exactly once every VOICES clocks.
- Stage 1 (clock t): register MAP_RATE <= rate_reg[slot] and slot_d <= slot, and set valid. Valid is 0 only in the first cycle after reset.
- Stage 2 (clock t+1): sample MAP_TR for voice v = slot_d.
  - If ACTIVE[v] and cnt[v] == 0: cnt[v] <= MAP_TR; STEP_TICK <= 1; STEP_VOICE <= v.
  - If ACTIVE[v] and cnt[v] != 0: cnt[v] <= cnt[v] - 1; STEP_TICK <= 0.
  - If not ACTIVE[v]: cnt[v] holds; STEP_TICK <= 0.
- Latency: STEP_TICK is registered and asserts 2 clocks after the slot counter selects the voice.
- Tick period for a steady rate: (MAP_TR + 1) visits = (MAP_TR + 1) * VOICES clocks.
- Counter arithmetic: 15-bit unsigned. The decrement never occurs at 0, so there is no wrap.
- Rate writes: rate_reg[WR_VOICE] <= WR_DATA at the next clock edge.
  - A write that coincides with stage 1 of the same voice: stage 1 captures the OLD value; the new value is used from the next visit.
  - An in-progress count is not restarted by a rate write.
- KEY_ON: ACTIVE[KEY_VOICE] <= 1 and cnt[KEY_VOICE] <= 0. The first tick for that voice occurs on its next stage-2 visit.
- KEY_OFF: ACTIVE[KEY_VOICE] <= 0; cnt holds.
- KEY_ON and KEY_OFF asserted together: KEY_ON wins.
- KEY_ON in the same cycle as a stage-2 update of the same voice: key-on wins. cnt = 0, no tick is emitted from that update, and ACTIVE = 1.
- KEY_OFF in the same cycle as a stage-2 update of the same voice: the stage-2 tick and update still complete; ACTIVE clears.
- WR_EN and KEY strobes to different or identical voices in the same cycle are independent and both take effect.
- Reset mid-operation: all state returns to reset values immediately. No tick pulse may be produced during or on the first clock after reset release.

Test Plan:
- Reset, then KEY_ON voice 3 with rate 0x00 (mapper gives 0x7FFF) -> first STEP_TICK with STEP_VOICE=3 on voice 3's next visit; the next tick exactly 32768*8 = 262144 clocks later.
- Voice 5 at rate 0xFF (0x3C7F) and voice 0 at rate 0x40 (0x7FBF), both keyed on -> tick periods 15488*8 and 32704*8 clocks; ticks are never simultaneous and each carries the correct STEP_VOICE.
- KEY_OFF voice 2 mid-count, wait 1000 clocks, KEY_ON again -> no ticks while inactive; a tick on the first visit after key-on.
- Write rate 0x80 to voice 1 in the exact cycle its stage 1 occurs -> the current reload uses the old mapping; the following reload uses 0x7BFF.
- KEY_ON and KEY_OFF to voice 4 simultaneously, and KEY_ON coinciding with voice 4's stage-2 tick cycle -> ACTIVE[4]=1, no tick in that cycle, cnt=0.
- Assert nRESET low asynchronously mid-count with all voices active -> outputs clear without waiting for CLK; no STEP_TICK for 2 clocks after release; ACTIVE=0.

Source files
------------

// File: rtl/env_rate_sched.sv
// Envelope rate scheduler: one shared rate mapper, visited round-robin by VOICES channels.
// Each voice runs a 15-bit period down-counter and emits a step tick when its period elapses.
module env_rate_sched #(
  parameter int unsigned VOICES = 8,
  parameter int unsigned VW     = 3
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              WR_EN,
  input  logic [VW-1:0]     WR_VOICE,
  input  logic [7:0]        WR_DATA,
  input  logic              KEY_ON,
  input  logic              KEY_OFF,
  input  logic [VW-1:0]     KEY_VOICE,
  output logic [7:0]        MAP_RATE,
  input  logic [14:0]       MAP_TR,
  output logic              STEP_TICK,
  output logic [VW-1:0]     STEP_VOICE,
  output logic [VOICES-1:0] ACTIVE
);

  logic [VW-1:0]     slot_q;
  logic [VW-1:0]     stage_voice_q;
  logic              valid_q;
  logic [7:0]        map_rate_q;
  logic [7:0]        rate_q [VOICES];
  logic [7:0]        rate_d [VOICES];
  logic [14:0]       cnt_q  [VOICES];
  logic [14:0]       cnt_d  [VOICES];
  logic [VOICES-1:0] active_q, active_d;
  logic              tick_q, tick_d;
  logic [VW-1:0]     step_voice_q, step_voice_d;

  always_comb begin
    rate_d       = rate_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    tick_d       = 1'b0;
    step_voice_d = step_voice_q;

    if (WR_EN) begin
      rate_d[WR_VOICE] = WR_DATA;
    end

    // Stage 2: MAP_TR reflects map_rate_q, captured for stage_voice_q one clock earlier.
    if (valid_q && active_q[stage_voice_q]) begin
      if (cnt_q[stage_voice_q] == 15'd0) begin
        cnt_d[stage_voice_q] = MAP_TR;
        tick_d               = 1'b1;
        step_voice_d         = stage_voice_q;
      end else begin
        cnt_d[stage_voice_q] = cnt_q[stage_voice_q] - 15'd1;
      end
    end

    // Key-on overrides a same-voice stage-2 update; key-off only clears the active flag.
    if (KEY_ON) begin
      active_d[KEY_VOICE] = 1'b1;
      cnt_d[KEY_VOICE]    = 15'd0;
      if (valid_q && (KEY_VOICE == stage_voice_q)) begin
        tick_d       = 1'b0;
        step_voice_d = step_voice_q;
      end
    end else if (KEY_OFF) begin
      active_d[KEY_VOICE] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      slot_q        <= '0;
      stage_voice_q <= '0;
      valid_q       <= 1'b0;
      map_rate_q    <= 8'h00;
      rate_q        <= '{default: '0};
      cnt_q         <= '{default: '0};
      active_q      <= '0;
      tick_q        <= 1'b0;
      step_voice_q  <= '0;
    end else begin
      slot_q        <= slot_q + VW'(1);
      stage_voice_q <= slot_q;
      valid_q       <= 1'b1;
      map_rate_q    <= rate_q[slot_q];
      rate_q        <= rate_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      tick_q        <= tick_d;
      step_voice_q  <= step_voice_d;
    end
  end

  assign MAP_RATE   = map_rate_q;
  assign STEP_TICK  = tick_q;
  assign STEP_VOICE = step_voice_q;
  assign ACTIVE     = active_q;

endmodule

// File: tb/tb_env_rate_sched.sv
// Directed bench for env_rate_sched. The mapper stand-in is MAP_TR = MAP_RATE, so a steady
// rate r gives a tick every (r + 1) * 8 clocks.
module tb_env_rate_sched;

  localparam int unsigned VOICES = 8;
  localparam int unsigned VW     = 3;

  logic              CLK = 1'b0;
  logic              nRESET = 1'b0;
  logic              WR_EN = 1'b0;
  logic [VW-1:0]     WR_VOICE = '0;
  logic [7:0]        WR_DATA = '0;
  logic              KEY_ON = 1'b0;
  logic              KEY_OFF = 1'b0;
  logic [VW-1:0]     KEY_VOICE = '0;
  logic [7:0]        MAP_RATE;
  logic [14:0]       MAP_TR;
  logic              STEP_TICK;
  logic [VW-1:0]     STEP_VOICE;
  logic [VOICES-1:0] ACTIVE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  env_rate_sched #(.VOICES(VOICES), .VW(VW)) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .WR_EN     (WR_EN),
    .WR_VOICE  (WR_VOICE),
    .WR_DATA   (WR_DATA),
    .KEY_ON    (KEY_ON),
    .KEY_OFF   (KEY_OFF),
    .KEY_VOICE (KEY_VOICE),
    .MAP_RATE  (MAP_RATE),
    .MAP_TR    (MAP_TR),
    .STEP_TICK (STEP_TICK),
    .STEP_VOICE(STEP_VOICE),
    .ACTIVE    (ACTIVE)
  );

  assign MAP_TR = {7'b0, MAP_RATE};

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the strobe edge.
  task automatic key(input logic on, input logic off, input logic [VW-1:0] v);
    KEY_ON = on; KEY_OFF = off; KEY_VOICE = v;
    @(negedge CLK);
    KEY_ON = 1'b0; KEY_OFF = 1'b0;
  endtask

  task automatic wr(input logic [VW-1:0] v, input logic [7:0] d);
    WR_EN = 1'b1; WR_VOICE = v; WR_DATA = d;
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_tick(input string tag, input int budget, output int t,
                           output logic [VW-1:0] v);
    logic found;
    int   n;
    found = 1'b0; n = 0; t = -1; v = '0;
    while (!found && n < budget) begin
      @(negedge CLK);
      n++;
      if (STEP_TICK) begin
        found = 1'b1; t = cyc; v = STEP_VOICE;
      end
    end
    check_eq({tag, "_seen"}, found, 1);
  endtask

  initial begin
    int t0, t1, t2, t3, tk, last0, last5, n0, n5, quiet;
    logic [VW-1:0] v;

    repeat (2) @(negedge CLK);
    check_eq("rst_map_rate", MAP_RATE, 0);
    check_eq("rst_tick", STEP_TICK, 0);
    check_eq("rst_step_voice", STEP_VOICE, 0);
    check_eq("rst_active", ACTIVE, 0);
    nRESET = 1'b1;
    @(negedge CLK);

    // Voice 3 at rate 0: first tick on next visit, then every 8 clocks.
    wr(3, 8'h00);
    key(1'b1, 1'b0, 3);
    check_eq("t1_active3", ACTIVE[3], 1);
    wait_tick("t1_first", 16, t0, v);
    check_eq("t1_voice_a", v, 3);
    wait_tick("t1_second", 16, t1, v);
    check_eq("t1_voice_b", v, 3);
    check_eq("t1_period", t1 - t0, 8);
    key(1'b0, 1'b1, 3);
    check_eq("t1_keyoff", ACTIVE, 0);

    // Voice 5 at rate 3 (32 clocks) and voice 0 at rate 5 (48 clocks) interleaved.
    wr(5, 8'h03);
    wr(0, 8'h05);
    key(1'b1, 1'b0, 5);
    key(1'b1, 1'b0, 0);
    last0 = -1; last5 = -1; n0 = 0; n5 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (STEP_TICK) begin
        check_eq("t2_voice_valid", (STEP_VOICE == 0) || (STEP_VOICE == 5), 1);
        if (STEP_VOICE == 5) begin
          if (last5 >= 0) check_eq("t2_period5", cyc - last5, 32);
          last5 = cyc; n5++;
        end else if (STEP_VOICE == 0) begin
          if (last0 >= 0) check_eq("t2_period0", cyc - last0, 48);
          last0 = cyc; n0++;
        end
      end
    end
    check_eq("t2_count5", n5 >= 5, 1);
    check_eq("t2_count0", n0 >= 4, 1);
    key(1'b0, 1'b1, 5);
    key(1'b0, 1'b1, 0);

    // Key-off voice 2 mid-count, stay quiet, then key-on ticks on the first visit.
    wr(2, 8'h04);
    key(1'b1, 1'b0, 2);
    wait_tick("t3_first", 16, t0, v);
    check_eq("t3_voice", v, 2);
    repeat (10) @(negedge CLK);
    key(1'b0, 1'b1, 2);
    check_eq("t3_inactive", ACTIVE, 0);
    quiet = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (STEP_TICK) quiet++;
    end
    check_eq("t3_quiet_ticks", quiet, 0);
    key(1'b1, 1'b0, 2);
    tk = cyc;
    wait_tick("t3_rekey", 16, t1, v);
    check_eq("t3_rekey_voice", v, 2);
    check_eq("t3_rekey_latency", (t1 - tk) <= 8, 1);
    key(1'b0, 1'b1, 2);

    // Rate write landing on voice 1's stage 1: that visit reloads the old rate.
    wr(1, 8'h00);
    key(1'b1, 1'b0, 1);
    wait_tick("t4_first", 16, t0, v);
    check_eq("t4_voice", v, 1);
    repeat (6) @(negedge CLK);
    wr(1, 8'h03);
    wait_tick("t4_a", 16, t1, v);
    check_eq("t4_old_reload_a", t1 - t0, 8);
    wait_tick("t4_b", 16, t2, v);
    check_eq("t4_old_reload_b", t2 - t1, 8);
    wait_tick("t4_c", 48, t3, v);
    check_eq("t4_new_reload", t3 - t2, 32);
    check_eq("t4_voice_c", v, 1);
    key(1'b0, 1'b1, 1);

    // Voice 4: simultaneous on/off, then key-on colliding with its stage-2 tick.
    wr(4, 8'h02);
    key(1'b1, 1'b1, 4);
    check_eq("t5_on_wins", ACTIVE[4], 1);
    wait_tick("t5_first", 16, t0, v);
    check_eq("t5_voice", v, 4);
    wait_tick("t5_second", 32, t1, v);
    check_eq("t5_period", t1 - t0, 24);
    repeat (23) @(negedge CLK);
    key(1'b1, 1'b0, 4);
    check_eq("t5_no_tick", STEP_TICK, 0);
    check_eq("t5_active", ACTIVE[4], 1);
    wait_tick("t5_after", 16, t2, v);
    check_eq("t5_restart", t2 - t1, 32);
    wait_tick("t5_reload", 32, t3, v);
    check_eq("t5_reload_period", t3 - t2, 24);

    // Asynchronous reset with every voice active.
    for (int i = 0; i < VOICES; i++) key(1'b1, 1'b0, VW'(i));
    repeat (5) @(negedge CLK);
    check_eq("t6_all_active", ACTIVE, 8'hFF);
    #2 nRESET = 1'b0;
    #1;
    check_eq("t6_async_active", ACTIVE, 0);
    check_eq("t6_async_tick", STEP_TICK, 0);
    check_eq("t6_async_rate", MAP_RATE, 0);
    @(negedge CLK);
    nRESET = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check_eq("t6_post_tick", STEP_TICK, 0);
    end
    check_eq("t6_post_active", ACTIVE, 0);
    key(1'b1, 1'b0, 5);
    wait_tick("t6_a", 16, t0, v);
    wait_tick("t6_b", 16, t1, v);
    check_eq("t6_rate_cleared", t1 - t0, 8);
    check_eq("t6_voice", v, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
